// File: rtl/sdrc_app_arb_pkg.sv
// Shared definitions for the SDRAM application-port arbiter: FSM encodings
// and the owner-index width helper.
package sdrc_app_arb_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] WR_DATA = 2'd2;

    // A single-port configuration still needs a 1-bit owner index.
    function automatic int owner_w(input int np);
        return (np > 1) ? $clog2(np) : 1;
    endfunction

endpackage

// File: rtl/sdrc_arb_tagfifo.sv
// Small synchronous FIFO of owner tags; tracks which master issued each
// outstanding read so returns can be routed back in order.
module sdrc_arb_tagfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so push+pop while full is legal.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter sharing one SDRAM controller application port among NP
// masters; steers write data from the owner and routes read returns by tag.
module sdrc_app_arb
    import sdrc_app_arb_pkg::*;
#(
    parameter int NP       = 4,
    parameter int APP_AW   = 26,
    parameter int dw       = 32,
    parameter int bl       = 9,
    parameter int RD_DEPTH = 4
) (
    input  logic                    sdram_clk,
    input  logic                    sdram_resetn,
    input  logic                    sdr_init_done,
    input  logic [NP-1:0]           m_req,
    input  logic [NP*APP_AW-1:0]    m_req_addr,
    input  logic [NP*bl-1:0]        m_req_len,
    input  logic [NP-1:0]           m_req_wr_n,
    output logic [NP-1:0]           m_ack,
    input  logic [NP*dw-1:0]        m_wr_data,
    input  logic [NP*dw/8-1:0]      m_wr_en_n,
    output logic [NP-1:0]           m_wr_next,
    output logic [NP-1:0]           m_rd_valid,
    output logic [NP-1:0]           m_last_rd,
    output logic [dw-1:0]           m_rd_data,
    output logic                    app_req,
    output logic [APP_AW-1:0]       app_req_addr,
    output logic [bl-1:0]           app_req_len,
    output logic                    app_req_wr_n,
    input  logic                    app_req_ack,
    output logic [dw-1:0]           app_wr_data,
    output logic [dw/8-1:0]         app_wr_en_n,
    input  logic                    app_wr_next_req,
    input  logic                    app_rd_valid,
    input  logic                    app_last_rd,
    input  logic [dw-1:0]           app_rd_data,
    output logic [owner_w(NP)-1:0]  arb_owner
);
    localparam int OW = owner_w(NP);
    localparam int BW = dw / 8;

    logic [1:0]        r_state;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_rr_ptr;
    logic              r_app_req;
    logic [APP_AW-1:0] r_addr;
    logic [bl-1:0]     r_len;
    logic              r_wr_n;
    logic [bl-1:0]     r_beat_cnt;
    logic [NP-1:0]     r_m_ack;
    logic              r_rd_err;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [OW-1:0]     w_fifo_head;
    logic              w_push;
    logic              w_pop;
    logic [NP-1:0]     w_elig;
    logic [NP-1:0]     w_rot;
    logic              w_found;
    logic [OW:0]       w_sum;
    logic [OW-1:0]     w_pick;
    logic [APP_AW-1:0] w_sel_addr;
    logic [bl-1:0]     w_sel_len;
    logic              w_sel_wr_n;
    logic [dw-1:0]     w_own_data;
    logic [BW-1:0]     w_own_en_n;

    // A port whose m_ack is pulsing still shows its old m_req; mask it so it is not re-granted.
    assign w_elig = m_req & ~r_m_ack & (~m_req_wr_n | {NP{~w_fifo_full}});
    assign w_rot  = NP'({w_elig, w_elig} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (OW+1)'(i);
            end
        end
        w_pick = (w_sum >= (OW+1)'(NP)) ? OW'(w_sum - (OW+1)'(NP)) : w_sum[OW-1:0];
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_sel_wr_n = 1'b1;
        w_own_data = '0;
        w_own_en_n = '1;
        for (int i = 0; i < NP; i++) begin
            if (OW'(i) == w_pick) begin
                w_sel_addr = m_req_addr[i*APP_AW +: APP_AW];
                w_sel_len  = m_req_len[i*bl +: bl];
                w_sel_wr_n = m_req_wr_n[i];
            end
            if (OW'(i) == r_owner) begin
                w_own_data = m_wr_data[i*dw +: dw];
                w_own_en_n = m_wr_en_n[i*BW +: BW];
            end
        end
    end

    assign w_push = (r_state == REQ) & app_req_ack & r_wr_n;
    assign w_pop  = app_rd_valid & app_last_rd;

    sdrc_arb_tagfifo #(
        .DEPTH (RD_DEPTH),
        .W     (OW)
    ) u_tagfifo (
        .i_clk       (sdram_clk),
        .i_rst_n     (sdram_resetn),
        .i_push      (w_push),
        .i_push_data (r_owner),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_app_req  <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_wr_n     <= 1'b0;
            r_beat_cnt <= '0;
            r_m_ack    <= '0;
        end else begin
            r_m_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (sdr_init_done && w_found) begin
                        r_owner   <= w_pick;
                        r_addr    <= w_sel_addr;
                        r_len     <= w_sel_len;
                        r_wr_n    <= w_sel_wr_n;
                        r_app_req <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (app_req_ack) begin
                        r_app_req <= 1'b0;
                        r_m_ack   <= NP'(1) << r_owner;
                        r_rr_ptr  <= (r_owner == OW'(NP - 1)) ? '0 : r_owner + OW'(1);
                        if (r_wr_n) begin
                            r_state <= IDLE;
                        end else begin
                            r_beat_cnt <= (r_len == '0) ? bl'(1) : r_len;
                            r_state    <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (app_wr_next_req) begin
                        r_beat_cnt <= r_beat_cnt - bl'(1);
                        if (r_beat_cnt <= bl'(1)) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky flag: read data arrived with no outstanding tag to route it to.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) r_rd_err <= 1'b0;
        else               r_rd_err <= r_rd_err | (app_rd_valid & w_fifo_empty);
    end

    a_rd_orphan: assert property (@(posedge sdram_clk) disable iff (!sdram_resetn) !r_rd_err);

    assign app_req      = r_app_req;
    assign app_req_addr = r_addr;
    assign app_req_len  = r_len;
    assign app_req_wr_n = r_wr_n;
    assign arb_owner    = r_owner;
    assign m_ack        = r_m_ack;
    assign app_wr_data  = w_own_data;
    assign app_wr_en_n  = (r_state == WR_DATA) ? w_own_en_n : '1;
    assign m_wr_next    = (r_state == WR_DATA && app_wr_next_req) ? (NP'(1) << r_owner) : '0;
    assign m_rd_valid   = (app_rd_valid && !w_fifo_empty) ? (NP'(1) << w_fifo_head) : '0;
    assign m_last_rd    = (app_last_rd && !w_fifo_empty) ? (NP'(1) << w_fifo_head) : '0;
    assign m_rd_data    = app_rd_data;

endmodule
